mbist_resp_cmp: RTL and testbench

//  MBIST response analyser; sits directly downstream of the blanket pattern generator and the RAM under test.

---
 rtl/mbist_resp_cmp.sv | 189 ++++++++++++++++++
 tb/tb_mbist_resp_cmp.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mbist_resp_cmp.sv
// MBIST response analyser: compares RAM read data against the pattern generator's expected data,
// counts mismatches, logs the first failures in a poppable FIFO and reports done/pass.
module mbist_resp_cmp #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned LOG_DEPTH = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] exp_dat_in,
    input  logic              w_en_in,
    input  logic              gen_done_in,
    input  logic [DATA_W-1:0] mem_dat_in,
    input  logic              log_pop_in,
    output logic              fail_out,
    output logic [CNT_W-1:0]  fail_cnt_out,
    output logic              log_valid_out,
    output logic [ADDR_W-1:0] log_addr_out,
    output logic [DATA_W-1:0] log_exp_out,
    output logic [DATA_W-1:0] log_got_out,
    output logic              log_ovf_out,
    output logic              done_out,
    output logic              pass_out
);

    localparam int unsigned PTR_W = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
    localparam int unsigned LAT_W = $clog2(RD_LAT + 1);
    localparam logic [PTR_W:0]   LOG_FULL   = (PTR_W + 1)'(LOG_DEPTH);
    localparam logic [LAT_W-1:0] DRAIN_LAST = LAT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e            state_q;
    logic [LAT_W-1:0]  drain_q;
    logic              fail_q, done_q, ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q;

    logic [RD_LAT-1:0] pipe_vld_q;
    logic [ADDR_W-1:0] pipe_addr_q [RD_LAT];
    logic [DATA_W-1:0] pipe_exp_q  [RD_LAT];

    logic [ADDR_W-1:0] log_addr_q [LOG_DEPTH];
    logic [DATA_W-1:0] log_exp_q  [LOG_DEPTH];
    logic [DATA_W-1:0] log_got_q  [LOG_DEPTH];
    logic [ADDR_W-1:0] log_addr_d [LOG_DEPTH];
    logic [DATA_W-1:0] log_exp_d  [LOG_DEPTH];
    logic [DATA_W-1:0] log_got_d  [LOG_DEPTH];
    logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [PTR_W:0]    lcnt_q, lcnt_d;
    logic [ADDR_W-1:0] head_addr_q, head_addr_d;
    logic [DATA_W-1:0] head_exp_q, head_exp_d, head_got_q, head_got_d;

    logic start, capture, flush, mis, pop, push;

    assign start   = (state_q == StIdle) && en_in;
    assign capture = (state_q == StRun) && en_in && !w_en_in;
    assign flush   = (state_q == StRun) && !en_in;
    assign mis     = pipe_vld_q[RD_LAT-1] && (mem_dat_in != pipe_exp_q[RD_LAT-1]);
    assign pop     = log_pop_in && (lcnt_q != '0);
    // A full log still accepts a mismatch when the head is popped in the same cycle.
    assign push    = mis && ((lcnt_q != LOG_FULL) || pop);

    always_comb begin
        log_addr_d = log_addr_q;
        log_exp_d  = log_exp_q;
        log_got_d  = log_got_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        lcnt_d     = lcnt_q;
        ovf_d      = ovf_q;
        if (start) begin
            wr_d   = '0;
            rd_d   = '0;
            lcnt_d = '0;
            ovf_d  = 1'b0;
        end else begin
            if (pop) rd_d = rd_q + 1'b1;
            if (push) begin
                log_addr_d[wr_q] = pipe_addr_q[RD_LAT-1];
                log_exp_d[wr_q]  = pipe_exp_q[RD_LAT-1];
                log_got_d[wr_q]  = mem_dat_in;
                wr_d             = wr_q + 1'b1;
            end else if (mis) begin
                ovf_d = 1'b1;
            end
            if (push && !pop) lcnt_d = lcnt_q + 1'b1;
            else if (pop && !push) lcnt_d = lcnt_q - 1'b1;
        end
        head_addr_d = '0;
        head_exp_d  = '0;
        head_got_d  = '0;
        if (lcnt_d != '0) begin
            head_addr_d = log_addr_d[rd_d];
            head_exp_d  = log_exp_d[rd_d];
            head_got_d  = log_got_d[rd_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            drain_q     <= '0;
            fail_q      <= 1'b0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            pipe_vld_q  <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            lcnt_q      <= '0;
            head_addr_q <= '0;
            head_exp_q  <= '0;
            head_got_q  <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                pipe_addr_q[i] <= '0;
                pipe_exp_q[i]  <= '0;
            end
            for (int i = 0; i < int'(LOG_DEPTH); i++) begin
                log_addr_q[i] <= '0;
                log_exp_q[i]  <= '0;
                log_got_q[i]  <= '0;
            end
        end else begin
            pipe_vld_q[0]  <= capture;
            pipe_addr_q[0] <= addr_in;
            pipe_exp_q[0]  <= exp_dat_in;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_addr_q[i] <= pipe_addr_q[i-1];
                pipe_exp_q[i]  <= pipe_exp_q[i-1];
            end
            if (flush) pipe_vld_q <= '0;

            if (mis) begin
                fail_q <= 1'b1;
                if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            end

            unique case (state_q)
                StIdle: if (en_in) begin
                    state_q <= StRun;
                    fail_q  <= 1'b0;
                    cnt_q   <= '0;
                    done_q  <= 1'b0;
                end
                StRun: if (!en_in) begin
                    state_q <= StIdle;
                end else if (gen_done_in) begin
                    state_q <= StDrain;
                    drain_q <= '0;
                end
                StDrain: if (drain_q == DRAIN_LAST) begin
                    state_q <= StDone;
                    done_q  <= 1'b1;
                end else begin
                    drain_q <= drain_q + 1'b1;
                end
                StDone: if (!en_in) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase

            log_addr_q  <= log_addr_d;
            log_exp_q   <= log_exp_d;
            log_got_q   <= log_got_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            lcnt_q      <= lcnt_d;
            ovf_q       <= ovf_d;
            head_addr_q <= head_addr_d;
            head_exp_q  <= head_exp_d;
            head_got_q  <= head_got_d;
        end
    end

    assign fail_out      = fail_q;
    assign fail_cnt_out  = cnt_q;
    assign log_valid_out = (lcnt_q != '0);
    assign log_addr_out  = head_addr_q;
    assign log_exp_out   = head_exp_q;
    assign log_got_out   = head_got_q;
    assign log_ovf_out   = ovf_q;
    assign done_out      = done_q;
    assign pass_out      = done_q & ~fail_q;

endmodule

// File: tb/tb_mbist_resp_cmp.sv
// Directed bench for mbist_resp_cmp: default instance plus a CNT_W=3 instance for saturation.
module tb_mbist_resp_cmp;

    logic       clk = 1'b0;
    logic       rst, en, w_en, gen_done, log_pop;
    logic [7:0] addr;
    logic [3:0] exp_dat, mem;

    logic       fail, valid, ovf, done, pass;
    logic [7:0] cnt, h_addr;
    logic [3:0] h_exp, h_got;

    logic       fail3, valid3, ovf3, done3, pass3;
    logic [2:0] cnt3;
    logic [7:0] h_addr3;
    logic [3:0] h_exp3, h_got3;

    int vecs = 0;
    int errs = 0;
    logic [7:0] exp_heads [4];

    always #5 clk = ~clk;

    mbist_resp_cmp dut (
        .clk(clk), .rst(rst), .en_in(en), .addr_in(addr), .exp_dat_in(exp_dat), .w_en_in(w_en),
        .gen_done_in(gen_done), .mem_dat_in(mem), .log_pop_in(log_pop), .fail_out(fail),
        .fail_cnt_out(cnt), .log_valid_out(valid), .log_addr_out(h_addr), .log_exp_out(h_exp),
        .log_got_out(h_got), .log_ovf_out(ovf), .done_out(done), .pass_out(pass)
    );

    mbist_resp_cmp #(.CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .en_in(en), .addr_in(addr), .exp_dat_in(exp_dat), .w_en_in(w_en),
        .gen_done_in(gen_done), .mem_dat_in(mem), .log_pop_in(log_pop), .fail_out(fail3),
        .fail_cnt_out(cnt3), .log_valid_out(valid3), .log_addr_out(h_addr3), .log_exp_out(h_exp3),
        .log_got_out(h_got3), .log_ovf_out(ovf3), .done_out(done3), .pass_out(pass3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vecs++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic e, input logic [7:0] a, input logic w, input logic [3:0] m);
        en = e; addr = a; exp_dat = 4'hA; w_en = w; mem = m; gen_done = 1'b0; log_pop = 1'b0;
    endtask

    // Start cycle, n reads of 4'hA at addr 0..n-1 (bad[i] -> RAM returns 4'h2), then one drain cycle.
    task automatic do_run(input int n, input logic [15:0] bad, input int pop_at);
        set_in(1'b1, 8'h00, 1'b1, 4'h0);
        tick();
        for (int i = 0; i < n; i++) begin
            set_in(1'b1, 8'(i), 1'b0, (i > 0 && bad[i-1]) ? 4'h2 : 4'hA);
            gen_done = (i == n - 1);
            log_pop  = (i == pop_at);
            tick();
        end
        set_in(1'b1, 8'h00, 1'b1, bad[n-1] ? 4'h2 : 4'hA);
        tick();
    endtask

    task automatic end_run();
        set_in(1'b0, 8'h00, 1'b1, 4'h0);
        tick();
    endtask

    task automatic pop_head();
        log_pop = 1'b1;
        tick();
        log_pop = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, 8'h00, 1'b0, 4'h0);
        tick();
        tick();
        chk("rst_fail", fail, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_valid", valid, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_head", {h_addr, h_exp, h_got}, 0);
        rst = 1'b0;
        tick();

        // T1: clean run, done two cycles after gen_done
        do_run(16, 16'h0000, -1);
        chk("t1_done", done, 1);
        chk("t1_pass", pass, 1);
        chk("t1_cnt", cnt, 0);
        chk("t1_valid", valid, 0);
        end_run();

        // T2: single mismatch at address 5
        do_run(16, 16'h0020, -1);
        chk("t2_fail", fail, 1);
        chk("t2_cnt", cnt, 1);
        chk("t2_pass", pass, 0);
        chk("t2_done", done, 1);
        chk("t2_head", {valid, h_addr, h_exp, h_got}, {1'b1, 8'h05, 4'hA, 4'h2});
        chk("t2_ovf", ovf, 0);
        end_run();

        // T3: six mismatches, log keeps first four and flags overflow
        do_run(8, 16'h007E, -1);
        chk("t3_cnt", cnt, 6);
        chk("t3_ovf", ovf, 1);
        for (int k = 1; k <= 4; k++) begin
            chk("t3_pop_head", {valid, h_addr, h_exp, h_got}, {1'b1, 8'(k), 4'hA, 4'h2});
            pop_head();
        end
        chk("t3_empty", {valid, h_addr}, 0);
        pop_head();
        chk("t3_pop_empty", valid, 0);
        end_run();

        // T4: mismatch on addr 5 arrives while log full and head popped
        do_run(8, 16'h003E, 6);
        chk("t4_cnt", cnt, 5);
        chk("t4_ovf", ovf, 0);
        exp_heads[0] = 8'h02; exp_heads[1] = 8'h03; exp_heads[2] = 8'h04; exp_heads[3] = 8'h05;
        for (int k = 0; k < 4; k++) begin
            chk("t4_pop_head", {valid, h_addr}, {1'b1, exp_heads[k]});
            pop_head();
        end
        chk("t4_empty", valid, 0);
        end_run();

        // T5: writes with wrong RAM data never compare; abort keeps results; restart clears
        set_in(1'b1, 8'h00, 1'b1, 4'h0); tick();
        set_in(1'b1, 8'h00, 1'b1, 4'h5); tick();
        set_in(1'b1, 8'h01, 1'b0, 4'h5); tick();
        set_in(1'b1, 8'h02, 1'b1, 4'hA); tick();
        set_in(1'b1, 8'h03, 1'b1, 4'h5); tick();
        chk("t5_wr_nofail", {fail, cnt}, 0);
        set_in(1'b1, 8'h04, 1'b0, 4'h5); tick();
        set_in(1'b1, 8'h05, 1'b1, 4'h3); tick();
        set_in(1'b1, 8'h06, 1'b1, 4'h5); tick();
        chk("t5_rd_fail", {fail, cnt, h_addr, h_got}, {1'b1, 8'd1, 8'h04, 4'h3});
        end_run();
        chk("t5_abort_done", done, 0);
        chk("t5_abort_kept", {fail, cnt}, {1'b1, 8'd1});
        set_in(1'b1, 8'h00, 1'b1, 4'h0); tick();
        chk("t5_restart_clr", {fail, cnt, valid, ovf, done}, 0);
        end_run();

        // T6: saturation on the 3-bit counter, then async reset mid-run
        do_run(11, 16'h07FE, -1);
        chk("t6_cnt8", cnt, 10);
        chk("t6_cnt3", cnt3, 7);
        chk("t6_ovf", ovf, 1);
        end_run();
        set_in(1'b1, 8'h00, 1'b1, 4'h0); tick();
        set_in(1'b1, 8'h01, 1'b0, 4'h0); tick();
        set_in(1'b1, 8'h02, 1'b0, 4'h2); tick();
        set_in(1'b1, 8'h03, 1'b0, 4'h2); tick();
        chk("t6_midrun_fail", {fail, cnt}, {1'b1, 8'd2});
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_dut", {fail, cnt, valid, h_addr, h_exp, h_got, ovf, done, pass}, 0);
        chk("t6_rst_dut3", {fail3, cnt3, valid3, ovf3, done3, pass3}, 0);
        #1 rst = 1'b0;
        set_in(1'b0, 8'h00, 1'b0, 4'h0);
        tick();
        chk("t6_post_rst", {fail, cnt, done}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
